// File: rtl/vga_sync_gen.sv
// VGA sync generator: edge-detects the divided pixel-rate level into a
// one-clk pixel strobe and runs horizontal/vertical scan counters from it,
// decoding hsync/vsync, active video and pixel coordinates.
// Optional: define VGA_SYNC_FRAME_CNT_EN to build the 8-bit frame counter;
// otherwise frame_cnt is tied to zero.
module vga_sync_gen #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33,
  parameter logic        SYNC_POL = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clk_vga,
  output logic       pix_tick,
  output logic       hsync,
  output logic       vsync,
  output logic       active,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic       frame_start,
  output logic [7:0] frame_cnt
);

  localparam int unsigned CNT_W   = 10;
  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [CNT_W-1:0] H_LAST    = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST    = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_ACT_END = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_ACT_END = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] HS_START  = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] HS_END    = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] VS_START  = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] VS_END    = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

  logic             clk_vga_q, clk_vga_d;
  logic [CNT_W-1:0] h_cnt_q, h_cnt_d;
  logic [CNT_W-1:0] v_cnt_q, v_cnt_d;
  logic             frame_start_q, frame_start_d;

  // Rising edge of the divided pixel clock, visible in the same cycle
  assign pix_tick = clk_vga & ~clk_vga_q;

  // Scan counter advance and frame-wrap detection
  always_comb begin
    clk_vga_d     = clk_vga;
    h_cnt_d       = h_cnt_q;
    v_cnt_d       = v_cnt_q;
    frame_start_d = 1'b0;
    if (pix_tick) begin
      if (h_cnt_q == H_LAST) begin
        h_cnt_d = '0;
        if (v_cnt_q == V_LAST) begin
          v_cnt_d       = '0;
          frame_start_d = 1'b1;
        end else begin
          v_cnt_d = v_cnt_q + CNT_W'(1);
        end
      end else begin
        h_cnt_d = h_cnt_q + CNT_W'(1);
      end
    end
  end

  // State registers; reset wins over a coincident pixel strobe
  always_ff @(posedge clk) begin
    if (rst) begin
      clk_vga_q     <= 1'b0;
      h_cnt_q       <= '0;
      v_cnt_q       <= '0;
      frame_start_q <= 1'b0;
    end else begin
      clk_vga_q     <= clk_vga_d;
      h_cnt_q       <= h_cnt_d;
      v_cnt_q       <= v_cnt_d;
      frame_start_q <= frame_start_d;
    end
  end

  // Region decode from the registered counters
  always_comb begin
    active = (h_cnt_q < H_ACT_END) && (v_cnt_q < V_ACT_END);
    hsync  = ((h_cnt_q >= HS_START) && (h_cnt_q < HS_END)) ? SYNC_POL : ~SYNC_POL;
    vsync  = ((v_cnt_q >= VS_START) && (v_cnt_q < VS_END)) ? SYNC_POL : ~SYNC_POL;
  end

  assign x           = h_cnt_q;
  assign y           = v_cnt_q;
  assign frame_start = frame_start_q;

`ifdef VGA_SYNC_FRAME_CNT_EN
  logic [7:0] frame_cnt_q, frame_cnt_d;

  // Frame counter steps on the same edge that raises frame_start
  always_comb begin
    frame_cnt_d = frame_cnt_q;
    if (frame_start_d) begin
      frame_cnt_d = frame_cnt_q + 8'd1;
    end
  end

  // Frame counter register
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_cnt_q <= 8'd0;
    end else begin
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign frame_cnt = frame_cnt_q;
`else
  assign frame_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_vga_sync_gen.sv
// Self-checking bench for vga_sync_gen: a default-timing instance for line
// timing, strobe and reset behaviour, and a tiny-timing instance for
// full-frame vsync, frame_start and frame_cnt behaviour.
module tb_vga_sync_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       clk_vga_a, clk_vga_b;
  logic       pix_tick_a, hsync_a, vsync_a, active_a, frame_start_a;
  logic [9:0] x_a, y_a;
  logic [7:0] frame_cnt_a;
  logic       pix_tick_b, hsync_b, vsync_b, active_b, frame_start_b;
  logic [9:0] x_b, y_b;
  logic [7:0] frame_cnt_b;

  vga_sync_gen dut (
    .clk(clk), .rst(rst), .clk_vga(clk_vga_a), .pix_tick(pix_tick_a),
    .hsync(hsync_a), .vsync(vsync_a), .active(active_a), .x(x_a), .y(y_a),
    .frame_start(frame_start_a), .frame_cnt(frame_cnt_a)
  );

  // Tiny timing: 7 pixels per line (active 0..3, sync at 5), 5 lines (sync at 3)
  vga_sync_gen #(
    .H_ACTIVE(4), .H_FP(1), .H_SYNC(1), .H_BP(1),
    .V_ACTIVE(2), .V_FP(1), .V_SYNC(1), .V_BP(1)
  ) dut_s (
    .clk(clk), .rst(rst), .clk_vga(clk_vga_b), .pix_tick(pix_tick_b),
    .hsync(hsync_b), .vsync(vsync_b), .active(active_b), .x(x_b), .y(y_b),
    .frame_start(frame_start_b), .frame_cnt(frame_cnt_b)
  );

  int total = 0;
  int bad   = 0;
  int pend_a, ticks_a, pend_b, ticks_b;
  logic [1:0] div_a;
  bit auto_a, run_b;

  typedef struct {
    int   t;
    int   x;
    int   y;
    logic hs;
    logic vs;
    logic act;
  } vec_t;

  vec_t vt[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  // One clk: counters reflect all ticks seen so far, then drive and sample strobes
  task automatic step();
    @(posedge clk);
    #1;
    ticks_a = pend_a;
    ticks_b = pend_b;
    if (auto_a) begin
      div_a     = div_a + 2'd1;
      clk_vga_a = div_a[1];
    end
    if (run_b) clk_vga_b = ~clk_vga_b;
    #1;
    if (pix_tick_a) pend_a++;
    if (pix_tick_b) pend_b++;
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    auto_a    = 1'b0;
    run_b     = 1'b0;
    clk_vga_a = 1'b0;
    clk_vga_b = 1'b0;
    div_a     = 2'd0;
    @(posedge clk);
    #1;
    rst    = 1'b0;
    pend_a = 0; ticks_a = 0;
    pend_b = 0; ticks_b = 0;
    #1;
    check("rst_x", 32'(x_a), 0);
    check("rst_y", 32'(y_a), 0);
    check("rst_hsync", 32'(hsync_a), 1);
    check("rst_vsync", 32'(vsync_a), 1);
    check("rst_active", 32'(active_a), 1);
    check("rst_frame_start", 32'(frame_start_a), 0);
    check("rst_frame_cnt", 32'(frame_cnt_a), 0);
    check("rst_pix_tick", 32'(pix_tick_a), 0);
  endtask

  task automatic advance_a(input int n_ticks);
    int n = 0;
    while (ticks_a < n_ticks && n < 10000) begin
      step();
      n++;
    end
    if (ticks_a != n_ticks) check("advance_timeout", 32'(ticks_a), 32'(n_ticks));
  endtask

  initial begin
    int p0;
    int prev_t, fs_pulses, fs_err, model_err, fc_err, n;
    int ex, ey, exp_fc;
    bit changed;

    vt[0]  = '{0,    0,   0, 1'b1, 1'b1, 1'b1};
    vt[1]  = '{1,    1,   0, 1'b1, 1'b1, 1'b1};
    vt[2]  = '{639,  639, 0, 1'b1, 1'b1, 1'b1};
    vt[3]  = '{640,  640, 0, 1'b1, 1'b1, 1'b0};
    vt[4]  = '{655,  655, 0, 1'b1, 1'b1, 1'b0};
    vt[5]  = '{656,  656, 0, 1'b0, 1'b1, 1'b0};
    vt[6]  = '{751,  751, 0, 1'b0, 1'b1, 1'b0};
    vt[7]  = '{752,  752, 0, 1'b1, 1'b1, 1'b0};
    vt[8]  = '{799,  799, 0, 1'b1, 1'b1, 1'b0};
    vt[9]  = '{800,  0,   1, 1'b1, 1'b1, 1'b1};
    vt[10] = '{801,  1,   1, 1'b1, 1'b1, 1'b1};
    vt[11] = '{1100, 300, 1, 1'b1, 1'b1, 1'b1};

    do_reset();

    // Line timing at default parameters, clk_vga = divider bit 1
    auto_a = 1'b1;
    foreach (vt[i]) begin
      advance_a(vt[i].t);
      check($sformatf("vec%0d_x", i), 32'(x_a), 32'(vt[i].x));
      check($sformatf("vec%0d_y", i), 32'(y_a), 32'(vt[i].y));
      check($sformatf("vec%0d_hsync", i), 32'(hsync_a), 32'(vt[i].hs));
      check($sformatf("vec%0d_vsync", i), 32'(vsync_a), 32'(vt[i].vs));
      check($sformatf("vec%0d_active", i), 32'(active_a), 32'(vt[i].act));
      check($sformatf("vec%0d_frame_start", i), 32'(frame_start_a), 0);
    end

    // clk_vga held high for 20 clk gives exactly one strobe
    auto_a    = 1'b0;
    clk_vga_a = 1'b0;
    step();
    step();
    check("hold_pre_x", 32'(x_a), 300);
    p0        = pend_a;
    clk_vga_a = 1'b1;
    #1;
    if (pix_tick_a) pend_a++;
    repeat (20) step();
    check("hold_ticks", 32'(pend_a - p0), 1);
    check("hold_x", 32'(x_a), 301);

    // Strobe period of 4 clk from the free-running divider
    clk_vga_a = 1'b0;
    div_a     = 2'd0;
    auto_a    = 1'b1;
    p0        = pend_a;
    repeat (40) step();
    check("period_ticks", 32'(pend_a - p0), 10);
    check("period_x", 32'(x_a), 311);

    // Reset mid-line with a coincident strobe returns to (0,0) without frame_start
    auto_a    = 1'b0;
    clk_vga_a = 1'b0;
    step();
    rst       = 1'b1;
    clk_vga_a = 1'b1;
    #1;
    check("rst_mid_tick", 32'(pix_tick_a), 1);
    @(posedge clk);
    #1;
    rst       = 1'b0;
    clk_vga_a = 1'b0;
    #1;
    check("rst_mid_x", 32'(x_a), 0);
    check("rst_mid_y", 32'(y_a), 0);
    check("rst_mid_hsync", 32'(hsync_a), 1);
    check("rst_mid_vsync", 32'(vsync_a), 1);
    check("rst_mid_active", 32'(active_a), 1);
    check("rst_mid_frame_start", 32'(frame_start_a), 0);
    @(posedge clk);
    #1;
    check("rst_mid_frame_start2", 32'(frame_start_a), 0);
    check("rst_mid_x2", 32'(x_a), 0);

    // Tiny timing: 257 full frames, strobe every 2 clk
    do_reset();
    run_b     = 1'b1;
    prev_t    = -1;
    fs_pulses = 0;
    fs_err    = 0;
    model_err = 0;
    fc_err    = 0;
    n         = 0;
    while (ticks_b < 257 * 35 && n < 20000) begin
      step();
      n++;
      changed = (ticks_b != prev_t);
      if (frame_start_b) fs_pulses++;
      if (frame_start_b !== (changed && ticks_b > 0 && (ticks_b % 35) == 0)) fs_err++;
`ifdef VGA_SYNC_FRAME_CNT_EN
      exp_fc = (ticks_b / 35) % 256;
`else
      exp_fc = 0;
`endif
      if (32'(frame_cnt_b) != exp_fc) fc_err++;
      if (changed) begin
        ex = ticks_b % 7;
        ey = (ticks_b / 7) % 5;
        if (ticks_b <= 40) begin
          check($sformatf("small_t%0d_x", ticks_b), 32'(x_b), 32'(ex));
          check($sformatf("small_t%0d_y", ticks_b), 32'(y_b), 32'(ey));
        end
        if (hsync_b !== (ex != 5) || vsync_b !== (ey != 3) ||
            active_b !== (ex < 4 && ey < 2) || 32'(x_b) != ex || 32'(y_b) != ey)
          model_err++;
      end
      prev_t = ticks_b;
    end
    check("small_ticks_reached", 32'(ticks_b), 257 * 35);
    check("small_decode_errors", 32'(model_err), 0);
    check("small_frame_start_errors", 32'(fs_err), 0);
    check("small_frame_start_pulses", 32'(fs_pulses), 257);
    check("small_frame_cnt_errors", 32'(fc_err), 0);
`ifdef VGA_SYNC_FRAME_CNT_EN
    check("small_frame_cnt_final", 32'(frame_cnt_b), 1);
`else
    check("small_frame_cnt_final", 32'(frame_cnt_b), 0);
`endif
    check("small_final_x", 32'(x_b), 0);
    check("small_final_y", 32'(y_b), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
